turn_sequencer: RTL and testbench

Central game controller for SZACHY. It takes debounced square clicks from the cursor-tracking logic and sequences each move: validate the pick, request legal moves from the move generator, accept or reject the place, commit the move to the board register file, then hand the turn to the other side. It owns side-to-move and game-over state. It sits between the mouse/cursor logic, the move generator and the board storage.

---
 rtl/chess_pkg.sv | 35 +++
 rtl/turn_sequencer_if.sv | 32 +++
 rtl/turn_timeout_counter.sv | 24 ++
 rtl/turn_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_turn_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared types, piece encodings and small piece helpers for the SZACHY game controller.
package chess_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_GEN,
    S_SELECTED,
    S_CLR_SRC,
    S_WR_DST,
    S_SWITCH,
    S_OVER
  } state_t;

  localparam logic [3:0] EMPTY      = 4'd0;
  localparam logic [2:0] PAWN       = 3'd1;
  localparam logic [2:0] KNIGHT     = 3'd2;
  localparam logic [2:0] BISHOP     = 3'd3;
  localparam logic [2:0] ROOK       = 3'd4;
  localparam logic [2:0] QUEEN      = 3'd5;
  localparam logic [2:0] KING       = 3'd6;
  localparam int         COLOUR_BIT = 3;

  function automatic logic is_own(input logic [3:0] piece, input logic side);
    return (piece != EMPTY) && (piece[COLOUR_BIT] == side);
  endfunction

  // A pawn promotes on the far rank for its colour: row 7 for white, row 0 for black.
  function automatic logic is_promotion(input logic [3:0] piece, input logic [5:0] dst);
    logic [2:0] row;
    row = dst[5:3];
    return (piece[2:0] == PAWN) && (piece[COLOUR_BIT] ? (row == 3'd0) : (row == 3'd7));
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Bundle of the click, board, move-generator and status signals around the turn sequencer.
interface turn_sequencer_if;
  logic        click_valid;
  logic [5:0]  click_square;
  logic [5:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        mg_start;
  logic [5:0]  mg_square;
  logic        mg_done;
  logic [63:0] mg_moves;
  logic        side;
  logic        picked_valid;
  logic [5:0]  picked_square;
  logic [63:0] highlight;
  logic        game_over;
  logic        winner;

  modport master (
    input  click_valid, click_square, rd_data, mg_done, mg_moves,
    output rd_addr, wr_en, wr_addr, wr_data, mg_start, mg_square,
           side, picked_valid, picked_square, highlight, game_over, winner
  );

  modport slave (
    output click_valid, click_square, rd_data, mg_done, mg_moves,
    input  rd_addr, wr_en, wr_addr, wr_data, mg_start, mg_square,
           side, picked_valid, picked_square, highlight, game_over, winner
  );
endinterface

// File: rtl/turn_timeout_counter.sv
// Loadable down-counter; expire pulses on the last enabled cycle of the loaded window.
module turn_timeout_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expire
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else if (load)
      count_reg <= load_value;
    else if (en && (count_reg != '0))
      count_reg <= count_reg - 1'b1;
  end

  assign expire = en && !load && (count_reg == '0);
endmodule

// File: rtl/turn_sequencer.sv
// Game controller: sequences pick, move generation, place, board commit and turn hand-over.
module turn_sequencer
  import chess_pkg::*;
#(
  parameter int         MG_TIMEOUT   = 1024,
  parameter logic [2:0] PROMOTE_CODE = 3'd5
) (
  input  logic              clk,
  input  logic              rst,
  turn_sequencer_if.master  bus
);
  localparam int CW = (MG_TIMEOUT > 1) ? $clog2(MG_TIMEOUT) : 1;

  state_t      state_reg,         state_next;
  logic        side_reg,          side_next;
  logic        picked_valid_reg,  picked_valid_next;
  logic [5:0]  picked_square_reg, picked_square_next;
  logic [63:0] highlight_reg,     highlight_next;
  logic        game_over_reg,     game_over_next;
  logic        winner_reg,        winner_next;
  logic        mg_start_reg,      mg_start_next;
  logic [5:0]  mg_square_reg,     mg_square_next;
  logic [5:0]  dst_reg,           dst_next;
  logic [3:0]  captured_reg,      captured_next;
  logic [3:0]  moving_reg,        moving_next;

  logic        tmo_load;
  logic        tmo_expire;
  logic [5:0]  rd_addr_c;
  logic        wr_en_c;
  logic [5:0]  wr_addr_c;
  logic [3:0]  wr_data_c;

  turn_timeout_counter #(.WIDTH(CW)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load       (tmo_load),
    .load_value (CW'(MG_TIMEOUT - 1)),
    .en         (state_reg == S_GEN),
    .expire     (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      side_reg          <= 1'b0;
      picked_valid_reg  <= 1'b0;
      picked_square_reg <= '0;
      highlight_reg     <= '0;
      game_over_reg     <= 1'b0;
      winner_reg        <= 1'b0;
      mg_start_reg      <= 1'b0;
      mg_square_reg     <= '0;
      dst_reg           <= '0;
      captured_reg      <= EMPTY;
      moving_reg        <= EMPTY;
    end else begin
      state_reg         <= state_next;
      side_reg          <= side_next;
      picked_valid_reg  <= picked_valid_next;
      picked_square_reg <= picked_square_next;
      highlight_reg     <= highlight_next;
      game_over_reg     <= game_over_next;
      winner_reg        <= winner_next;
      mg_start_reg      <= mg_start_next;
      mg_square_reg     <= mg_square_next;
      dst_reg           <= dst_next;
      captured_reg      <= captured_next;
      moving_reg        <= moving_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    side_next          = side_reg;
    picked_valid_next  = picked_valid_reg;
    picked_square_next = picked_square_reg;
    highlight_next     = highlight_reg;
    game_over_next     = game_over_reg;
    winner_next        = winner_reg;
    mg_start_next      = 1'b0;
    mg_square_next     = mg_square_reg;
    dst_next           = dst_reg;
    captured_next      = captured_reg;
    moving_next        = moving_reg;
    tmo_load           = 1'b0;
    rd_addr_c          = '0;
    wr_en_c            = 1'b0;
    wr_addr_c          = '0;
    wr_data_c          = EMPTY;

    case (state_reg)
      S_IDLE: begin
        if (bus.click_valid) begin
          picked_square_next = bus.click_square;
          state_next         = S_CHECK;
        end
      end

      S_CHECK: begin
        rd_addr_c = picked_square_reg;
        if (is_own(bus.rd_data, side_reg)) begin
          mg_start_next  = 1'b1;
          mg_square_next = picked_square_reg;
          tmo_load       = 1'b1;
          state_next     = S_GEN;
        end else begin
          state_next = S_IDLE;
        end
      end

      // mg_done wins over a timeout landing in the same cycle.
      S_GEN: begin
        if (bus.mg_done) begin
          highlight_next    = bus.mg_moves;
          picked_valid_next = 1'b1;
          state_next        = S_SELECTED;
        end else if (tmo_expire) begin
          state_next = S_IDLE;
        end
      end

      S_SELECTED: begin
        rd_addr_c = bus.click_square;
        if (bus.click_valid) begin
          if (bus.click_square == picked_square_reg) begin
            picked_valid_next = 1'b0;
            highlight_next    = '0;
            state_next        = S_IDLE;
          end else if (highlight_reg[bus.click_square]) begin
            dst_next      = bus.click_square;
            captured_next = bus.rd_data;
            state_next    = S_CLR_SRC;
          end else if (is_own(bus.rd_data, side_reg)) begin
            picked_square_next = bus.click_square;
            picked_valid_next  = 1'b0;
            highlight_next     = '0;
            state_next         = S_CHECK;
          end
        end
      end

      // The source is still intact on the read port while its clear is being issued.
      S_CLR_SRC: begin
        rd_addr_c   = picked_square_reg;
        moving_next = bus.rd_data;
        wr_en_c     = 1'b1;
        wr_addr_c   = picked_square_reg;
        wr_data_c   = EMPTY;
        state_next  = S_WR_DST;
      end

      S_WR_DST: begin
        wr_en_c   = 1'b1;
        wr_addr_c = dst_reg;
        wr_data_c = is_promotion(moving_reg, dst_reg) ? {side_reg, PROMOTE_CODE} : moving_reg;
        picked_valid_next = 1'b0;
        highlight_next    = '0;
        state_next        = S_SWITCH;
      end

      S_SWITCH: begin
        if (captured_reg[2:0] == KING) begin
          game_over_next = 1'b1;
          winner_next    = side_reg;
          state_next     = S_OVER;
        end else begin
          side_next  = ~side_reg;
          state_next = S_IDLE;
        end
      end

      S_OVER: state_next = S_OVER;

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.rd_addr       = rd_addr_c;
  assign bus.wr_en         = wr_en_c;
  assign bus.wr_addr       = wr_addr_c;
  assign bus.wr_data       = wr_data_c;
  assign bus.mg_start      = mg_start_reg;
  assign bus.mg_square     = mg_square_reg;
  assign bus.side          = side_reg;
  assign bus.picked_valid  = picked_valid_reg;
  assign bus.picked_square = picked_square_reg;
  assign bus.highlight     = highlight_reg;
  assign bus.game_over     = game_over_reg;
  assign bus.winner        = winner_reg;
endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a board model and a queue of expected board writes.
module tb_turn_sequencer;
  localparam int TMO = 16;

  logic clk;
  logic rst;
  logic tb_clear;
  logic tb_load;
  logic [5:0] tb_addr;
  logic [3:0] tb_data;
  logic [3:0] board [64];
  logic [9:0] wq [$];
  int errors = 0;
  int checks = 0;

  turn_sequencer_if bus ();

  turn_sequencer #(.MG_TIMEOUT(TMO), .PROMOTE_CODE(3'd5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 64; i++) board[i] <= 4'h0;
    end else if (bus.wr_en) begin
      board[bus.wr_addr] <= bus.wr_data;
    end else if (tb_load) begin
      board[tb_addr] <= tb_data;
    end
  end

  assign bus.rd_data = board[bus.rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every board write is matched against the oldest expected (addr,data) entry.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        assert (0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr=%0d data=%0h expected no write", bus.wr_addr, bus.wr_data);
        end
      end else begin
        logic [9:0] e;
        e = wq.pop_front();
        $display("write addr=%0d data=%0h", bus.wr_addr, bus.wr_data);
        chk("board_write", {54'd0, bus.wr_addr, bus.wr_data}, {54'd0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [5:0] sq, input logic [3:0] val);
    tb_load = 1'b1; tb_addr = sq; tb_data = val;
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  task automatic click(input logic [5:0] sq);
    $display("click square=%0d side=%0d", sq, bus.side);
    bus.click_valid = 1'b1; bus.click_square = sq;
    @(negedge clk);
    bus.click_valid = 1'b0;
  endtask

  task automatic mg_reply(input logic [63:0] moves);
    bus.mg_done = 1'b1; bus.mg_moves = moves;
    @(negedge clk);
    bus.mg_done = 1'b0; bus.mg_moves = '0;
  endtask

  task automatic pick(input logic [5:0] sq, input logic [63:0] moves);
    click(sq);
    chk("mg_start_early", {63'd0, bus.mg_start}, 64'd0);
    tick(1);
    chk("mg_start", {63'd0, bus.mg_start}, 64'd1);
    chk("mg_square", {58'd0, bus.mg_square}, {58'd0, sq});
    mg_reply(moves);
    chk("picked_valid_set", {63'd0, bus.picked_valid}, 64'd1);
    chk("highlight", bus.highlight, moves);
  endtask

  // Returns four cycles after the place click, when the side toggle is visible.
  task automatic place(input logic [5:0] src, input logic [5:0] dst, input logic [3:0] data);
    wq.push_back({src, 4'h0});
    wq.push_back({dst, data});
    click(dst);
    chk("clr_src_addr", {57'd0, bus.wr_en, bus.wr_addr}, {57'd0, 1'b1, src});
    tick(1);
    chk("wr_dst", {53'd0, bus.wr_en, bus.wr_addr, bus.wr_data}, {53'd0, 1'b1, dst, data});
    tick(2);
    chk("wr_en_done", {63'd0, bus.wr_en}, 64'd0);
    chk("picked_cleared", {bus.highlight[62:0], bus.picked_valid}, 64'd0);
  endtask

  task automatic reject(input logic [5:0] sq);
    click(sq);
    chk("reject_mg_start1", {63'd0, bus.mg_start}, 64'd0);
    tick(1);
    chk("reject_mg_start2", {63'd0, bus.mg_start}, 64'd0);
    chk("reject_picked", {63'd0, bus.picked_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; tb_clear = 1'b1; tb_load = 1'b0; tb_addr = '0; tb_data = '0;
    bus.click_valid = 1'b0; bus.click_square = '0; bus.mg_done = 1'b0; bus.mg_moves = '0;
    tick(2);
    tb_clear = 1'b0;
    put(6'd8, 4'h1);
    put(6'd48, 4'h1);
    put(6'd50, 4'h9);
    chk("rst_side", {63'd0, bus.side}, 64'd0);
    chk("rst_picked", {57'd0, bus.picked_valid, bus.picked_square}, 64'd0);
    chk("rst_highlight", bus.highlight, 64'd0);
    chk("rst_over", {62'd0, bus.game_over, bus.winner}, 64'd0);
    chk("rst_strobes", {62'd0, bus.wr_en, bus.mg_start}, 64'd0);
    chk("rst_addrs", {52'd0, bus.rd_addr, bus.mg_square}, 64'd0);
    rst = 1'b0;
    tick(1);

    // White pawn 8 -> 24
    pick(6'd8, 64'h0000_0000_0101_0000);
    chk("picked_square", {58'd0, bus.picked_square}, 64'd8);
    place(6'd8, 6'd24, 4'h1);
    chk("side_after_move1", {63'd0, bus.side}, 64'd1);

    // Black: wrong colour, empty, then select/deselect
    reject(6'd24);
    reject(6'd40);
    pick(6'd50, 64'd1 << 42);
    click(6'd50);
    chk("deselect", {bus.highlight[62:0], bus.picked_valid}, 64'd0);

    // Generator timeout, then a stale mg_done in IDLE
    click(6'd50);
    tick(1);
    chk("tmo_mg_start", {63'd0, bus.mg_start}, 64'd1);
    tick(TMO);
    mg_reply(64'd1 << 42);
    chk("late_done_ignored", {bus.highlight[62:0], bus.picked_valid}, 64'd0);
    pick(6'd50, 64'd1 << 42);
    place(6'd50, 6'd42, 4'h9);
    chk("side_after_move2", {63'd0, bus.side}, 64'd0);

    // mg_done on the last cycle of the window is still accepted; then promotion
    click(6'd48);
    tick(1);
    chk("edge_mg_start", {63'd0, bus.mg_start}, 64'd1);
    tick(TMO - 1);
    mg_reply(64'd1 << 56);
    chk("edge_done_accepted", {63'd0, bus.picked_valid}, 64'd1);
    place(6'd48, 6'd56, 4'h5);
    chk("side_after_promo", {63'd0, bus.side}, 64'd1);

    pick(6'd42, 64'd1 << 34);
    place(6'd42, 6'd34, 4'h9);
    chk("side_after_move4", {63'd0, bus.side}, 64'd0);

    // King capture ends the game
    put(6'd33, 4'hE);
    pick(6'd24, 64'd1 << 33);
    place(6'd24, 6'd33, 4'h1);
    chk("game_over", {62'd0, bus.game_over, bus.winner}, 64'd2);
    chk("side_frozen", {63'd0, bus.side}, 64'd0);
    click(6'd33);
    tick(3);
    click(6'd8);
    tick(2);
    chk("over_no_mg_start", {63'd0, bus.mg_start}, 64'd0);
    chk("over_hold", {62'd0, bus.game_over, bus.picked_valid}, 64'd2);
    chk("write_queue_empty", 64'(wq.size()), 64'd0);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_clears_over", {62'd0, bus.game_over, bus.side}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
